// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display path and its inverse
// decoder. Both ends use this one code table so they can never disagree.
//
// Contents:
//   NDIG_C        number of decimal digits carried on a display bus
//   SEG_0..SEG_9  active-low segment codes, bit order gfedcba
//   SEG_BLANK     all segments off
//   state_t       FSM state encoding of the seven-segment decoder
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NDIG_C = 8;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational decode of one active-low seven-segment pattern.
//
// Ports:
//   i_seg     [6:0]  segment pattern, gfedcba, active-low
//   o_digit   [3:0]  decoded digit 0..9; 0 for blank or unrecognised patterns
//   o_valid          pattern is one of the ten digit codes
//   o_blank          pattern is the blank code (all segments off)
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_valid,
    output logic       o_blank
);

    always_comb begin
        o_digit = 4'd0;
        o_valid = 1'b1;
        o_blank = 1'b0;
        case (i_seg)
            SEG_0:     o_digit = 4'd0;
            SEG_1:     o_digit = 4'd1;
            SEG_2:     o_digit = 4'd2;
            SEG_3:     o_digit = 4'd3;
            SEG_4:     o_digit = 4'd4;
            SEG_5:     o_digit = 4'd5;
            SEG_6:     o_digit = 4'd6;
            SEG_7:     o_digit = 4'd7;
            SEG_8:     o_digit = 4'd8;
            SEG_9:     o_digit = 4'd9;
            SEG_BLANK: begin
                o_valid = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_to_bin.sv
// -----------------------------------------------------------------------------
// seg7_to_bin
// Sequential decoder: eight active-low seven-segment digit patterns back to a
// 32-bit unsigned binary value, most-significant digit first, one digit per
// clock.
//
// Handshake: start is taken only on a clock edge where ready=1; ready then
// drops until the FSM returns to IDLE. valid is a one-cycle pulse in the
// cycle result/err/err_pos were updated; there is no back-pressure on valid.
// start while ready=0 (including the DONE cycle) is dropped, not queued.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset
//   start               request conversion
//   seg_in   [7*NDIG-1:0] digit patterns, seg_in[6:0] = ones digit
//   ready               idle, can accept start
//   valid               one-cycle completion pulse
//   result   [31:0]     decoded value, held until next completion
//   err                 some digit of the last conversion was invalid
//   err_pos  [2:0]      index of the most-significant invalid digit
//   dbg_state           current FSM state
// -----------------------------------------------------------------------------
module seg7_to_bin
    import seg7_pkg::*;
#(
    parameter int NDIG          = NDIG_C,
    parameter bit BLANK_AS_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7*NDIG-1:0] seg_in,
    output logic              ready,
    output logic              valid,
    output logic [31:0]       result,
    output logic              err,
    output logic [2:0]        err_pos,
    output state_t            dbg_state
);

    // Digit index width; the design is fixed at 8 digits.
    localparam int CNT_W = 3;

    state_t            r_state;
    logic [7*NDIG-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_acc;
    // Running error status for the conversion in flight; the visible
    // err/err_pos only change at the completion edge.
    logic              r_err_run;
    logic [2:0]        r_pos_run;
    logic              r_ready;
    logic              r_valid;
    logic [31:0]       r_result;
    logic              r_err;
    logic [2:0]        r_err_pos;

    logic [6:0]  w_head;
    logic [3:0]  w_digit;
    logic        w_valid;
    logic        w_blank;
    logic        w_bad;
    logic [31:0] w_next_acc;

    // The most-significant unconsumed digit sits at the top of the shift
    // register; the register shifts left by one digit per CONV cycle.
    assign w_head = r_shift[7*NDIG-1 -: 7];

    seg7_decode u_decode (
        .i_seg   (w_head),
        .o_digit (w_digit),
        .o_valid (w_valid),
        .o_blank (w_blank)
    );

    assign w_bad      = ~w_valid & ~(w_blank & BLANK_AS_ZERO);
    assign w_next_acc = (r_acc << 3) + (r_acc << 1) + {28'd0, w_digit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_err_run <= 1'b0;
            r_pos_run <= 3'd0;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_result  <= 32'd0;
            r_err     <= 1'b0;
            r_err_pos <= 3'd0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift   <= seg_in;
                        r_acc     <= 32'd0;
                        r_err_run <= 1'b0;
                        r_pos_run <= 3'd0;
                        r_cnt     <= CNT_W'(NDIG - 1);
                        r_ready   <= 1'b0;
                        r_state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_acc   <= w_next_acc;
                    r_shift <= r_shift << 7;
                    // Only the first (most-significant) bad digit is recorded.
                    if (w_bad && !r_err_run) begin
                        r_err_run <= 1'b1;
                        r_pos_run <= r_cnt;
                    end
                    if (r_cnt == '0) begin
                        r_result  <= w_next_acc;
                        r_err     <= r_err_run | w_bad;
                        // A bad ones digit found here leaves err_pos at 0.
                        r_err_pos <= r_err_run ? r_pos_run : 3'd0;
                        r_valid   <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign valid     = r_valid;
    assign result    = r_result;
    assign err       = r_err;
    assign err_pos   = r_err_pos;
    assign dbg_state = r_state;

endmodule
